mac_seq_ctrl: RTL
=================

# mac_seq_ctrl

Sequencing controller for a single `mac_unit` datapath: accepts a dot-product job of length K, issues K operand-buffer reads, and drives the MAC's clear and enable strobes aligned to the buffer's 1-cycle read latency. It then captures the final accumulator value and presents it on a valid/ready result port. It sits between the tile command logic and one MAC plus its weight/activation buffers.

## Interface
- `DATA_WIDTH`, 8, operand width (INT8); informational, no operand path passes through this block.
- `ACC_WIDTH`, 32, accumulator/result width.
- `ADDR_WIDTH`, 8, operand buffer address width.
- `LEN_WIDTH`, 8, job length field width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  job request; sampled only in IDLE.
- `len`  in  LEN_WIDTH  K, number of MAC steps; latched on start.
- `base_addr`  in  ADDR_WIDTH  first operand address; latched on start.
- `abort`  in  1  cancel current job.
- `busy`  out  1  high in every state except IDLE.
- `rd_en`  out  1  operand buffer read strobe (weight and activation buffers share it).
- `rd_addr`  out  ADDR_WIDTH  operand read address.
- `mac_clear`  out  1  to MAC `clear_acc`.
- `mac_en`  out  1  to MAC `en`.
- `acc_in`  in  ACC_WIDTH  from MAC `acc_out`.
- `res_valid`  out  1  result available.
- `res_data`  out  ACC_WIDTH  captured dot-product result.
- `res_ready`  in  1  consumer accepts result.

## Operation
- States: IDLE, CLEAR, ISSUE, DRAIN, CAPTURE, OUT.
- IDLE:
  - If `start` and not `abort`: latch `len` and `base_addr`, clear the issue counter, go to CLEAR.
- CLEAR:
  - Assert `mac_clear` for 1 cycle.
  - Go to ISSUE if K>0; go to CAPTURE if K=0.
- ISSUE:
  - `rd_en`=1 and `rd_addr` = base + i, for i = 0..K-1, one read per cycle.
  - Address is computed modulo 2^ADDR_WIDTH, so it wraps silently.
  - After the issue with i = K-1, go to DRAIN.
- `mac_en` is `rd_en` delayed by one register stage, matching the buffer latency. `mac_en` is forced low on abort and on reset.
- DRAIN:
  - `rd_en`=0. `mac_en` is high for the last operand.
  - Go to CAPTURE.
- CAPTURE:
  - `acc_in` now holds the final sum; register it into `res_data`.
  - Go to OUT.
- OUT:
  - `res_valid`=1. `res_data` is held stable until `res_valid && res_ready`, then go to IDLE.
- `start` outside IDLE is ignored; no queueing.
- `abort` has priority over every other transition:
  - In any non-IDLE state, the next state is IDLE. `rd_en`, `mac_en`, `mac_clear` and `res_valid` are low from the next cycle, and no result is produced.
  - In IDLE, `abort` suppresses a simultaneous `start`.
- Partial MAC contents left by an abort are discarded by the next job's CLEAR.
- No arithmetic on data; `res_data` is a bit-exact copy of `acc_in` (signed, two's complement).

## Timing
- Reset (async assert, any state): state IDLE. `busy`, `rd_en`, `mac_clear`, `mac_en`, `res_valid` = 0; `rd_addr`, `res_data` = 0. Reset mid-job drops the job with no result.
- Cycle 0 is the IDLE cycle with `start` sampled high.
- Cycle numbering for K>0:
  - Cycle 1: CLEAR, `mac_clear`.
  - Cycles 2..K+1: ISSUE, `rd_en`.
  - Cycles 3..K+2: `mac_en` high (cycle K+2 is DRAIN).
  - Cycle K+3: CAPTURE.
  - Cycle K+4 onward: `res_valid`.
- K=0: CLEAR at cycle 1, CAPTURE at cycle 2, `res_valid` at cycle 3 with `res_data`=0. No `rd_en` or `mac_en`.
- `busy` is high from cycle 1 through the handshake cycle inclusive.
- A new `start` can be accepted in the first cycle after the handshake.
- Throughput with `res_ready` tied high: one job per K+5 cycles.

## Test plan
- Reset: assert `rst` mid-ISSUE with K=6.
  -> All outputs 0 immediately; no `res_valid` after release; next job correct.
- Basic: K=4, base=0x10, a=[1,2,3,4], b=[5,6,7,8], buffer model plus real `mac_unit`.
  -> `rd_addr` 0x10..0x13 in cycles 2..5.
  -> `mac_en` in cycles 3..6.
  -> `res_valid` at cycle 8 with `res_data`=70.
- Backpressure: basic job with `res_ready` low for 5 cycles, plus `start` pulses during OUT.
  -> `res_valid`=1 and `res_data`=70 stable throughout, starts ignored, `busy`=1.
  -> Single handshake, then IDLE.
- Wrap and K=0:
  - base=0xFE, K=4 -> addresses 0xFE, 0xFF, 0x00, 0x01.
  - K=0 -> `res_valid` at cycle 3, `res_data`=0, `rd_en` and `mac_en` never high.
- Abort: K=8 job, assert `abort` at cycle 4.
  -> IDLE next cycle, no `res_valid`.
  -> Follow-up K=2 job with a=[-128,127], b=[-128,-128] returns 128, proving CLEAR discards stale accumulation.
- Abort and start together in IDLE.
  -> No job starts, `busy` stays 0.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// Sequencer for one MAC datapath: issues K operand reads, strobes clear/enable
// in step with the 1-cycle buffer latency, then holds the sum on a valid/ready port.
module mac_seq_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  abort,
    output logic                  busy,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  mac_clear,
    output logic                  mac_en,
    input  logic [ACC_WIDTH-1:0]  acc_in,
    output logic                  res_valid,
    output logic [ACC_WIDTH-1:0]  res_data,
    input  logic                  res_ready
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        DRAIN,
        CAPTURE,
        OUT
    } state_t;

    // The accumulator must be able to hold at least one full operand product.
    if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_accTooNarrow
        $error("mac_seq_ctrl: ACC_WIDTH narrower than one operand product");
    end

    state_t                r_state;
    state_t                w_nextState;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic [ADDR_WIDTH-1:0] r_base;
    logic                  r_macEn;
    logic [ACC_WIDTH-1:0]  r_resData;
    logic                  w_accept;
    logic                  w_busy;
    logic                  w_rdEn;
    logic                  w_macClear;
    logic                  w_resValid;
    logic [ADDR_WIDTH-1:0] w_rdAddr;

    assign w_accept = (r_state == IDLE) && start && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = CLEAR;
            CLEAR:   w_nextState = (r_len == '0) ? CAPTURE : ISSUE;
            ISSUE:   if (r_cnt == r_len - LEN_WIDTH'(1)) w_nextState = DRAIN;
            DRAIN:   w_nextState = CAPTURE;
            CAPTURE: w_nextState = OUT;
            OUT:     if (res_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
        // Abort overrides every transition, including a start seen in IDLE.
        if (abort) w_nextState = IDLE;
    end

    always_comb begin
        w_busy     = (r_state != IDLE);
        w_rdEn     = (r_state == ISSUE);
        w_macClear = (r_state == CLEAR);
        w_resValid = (r_state == OUT);
        w_rdAddr   = '0;
        if (w_rdEn) w_rdAddr = r_base + ADDR_WIDTH'(r_cnt);
    end

    // Job registers, the MAC enable pipeline stage and the captured result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len     <= '0;
            r_base    <= '0;
            r_cnt     <= '0;
            r_macEn   <= 1'b0;
            r_resData <= '0;
        end else begin
            if (w_accept) begin
                r_len  <= len;
                r_base <= base_addr;
                r_cnt  <= '0;
            end else if (r_state == ISSUE) begin
                r_cnt <= r_cnt + LEN_WIDTH'(1);
            end
            r_macEn <= w_rdEn && !abort;
            if (r_state == CAPTURE && !abort) r_resData <= acc_in;
        end
    end

    assign busy      = w_busy;
    assign rd_en     = w_rdEn;
    assign rd_addr   = w_rdAddr;
    assign mac_clear = w_macClear;
    assign mac_en    = r_macEn;
    assign res_valid = w_resValid;
    assign res_data  = r_resData;

endmodule
